// File: rtl/distribute_1x2_comb.sv
// 1-to-2 distribution switch: steers one input word to the high branch, the low
// branch, both or neither. Purely combinational; clk exists only for interface uniformity.
module distribute_1x2_comb #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned COMMMAND_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH-1:0]     i_data_bus,
  input  logic                      i_en,
  input  logic [COMMMAND_WIDTH-1:0] i_cmd,
  output logic [1:0]                o_valid,
  output logic [2*DATA_WIDTH-1:0]   o_data_bus
);

  logic                  go;
  logic                  valid_high;
  logic                  valid_low;
  logic [DATA_WIDTH-1:0] data_high;
  logic [DATA_WIDTH-1:0] data_low;
  logic                  unused_clk;

  assign unused_clk = clk;

  // rst gates the outputs directly, so assertion and release take effect without a clock edge
  always_comb begin
    go         = ~rst & i_en & i_valid;
    valid_high = go & i_cmd[1];
    valid_low  = go & i_cmd[0];
    data_high  = '0;
    data_low   = '0;
    if (valid_high) data_high = i_data_bus;
    if (valid_low)  data_low  = i_data_bus;
  end

  assign o_valid    = {valid_high, valid_low};
  assign o_data_bus = {data_high, data_low};

endmodule

// File: tb/tb_distribute_1x2_comb.sv
// Directed table, hand-written sequences and random vectors for the 1x2 distribution switch.
module tb_distribute_1x2_comb;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic [DW-1:0] i_data_bus;
  logic          i_en;
  logic [1:0]    i_cmd;
  logic [1:0]    o_valid;
  logic [2*DW-1:0] o_data_bus;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  distribute_1x2_comb #(.DATA_WIDTH(DW), .COMMMAND_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_en       (i_en),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic        valid;
    logic [1:0]  cmd;
    logic [31:0] data;
    logic [1:0]  ev;
    logic [63:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic r, logic e, logic v, logic [1:0] c,
                              logic [31:0] d, logic [1:0] ev, logic [63:0] ed);
    vec_t t;
    t.name = n; t.rst = r; t.en = e; t.valid = v; t.cmd = c; t.data = d;
    t.ev = ev; t.ed = ed;
    return t;
  endfunction

  task automatic drive(input logic r, input logic e, input logic v,
                       input logic [1:0] c, input logic [31:0] d);
    rst = r; i_en = e; i_valid = v; i_cmd = c; i_data_bus = d;
  endtask

  task automatic check(input string name, input logic [1:0] ev, input logic [63:0] ed);
    total++;
    if (o_valid !== ev || o_data_bus !== ed) begin
      bad++;
      $display("FAIL %s: got valid=%b data=%h, expected valid=%b data=%h",
               name, o_valid, o_data_bus, ev, ed);
    end
  endtask

  // Reference written as a command decode rather than the bit equations
  task automatic model(input logic r, input logic e, input logic v, input logic [1:0] c,
                       input logic [31:0] d, output logic [1:0] ev, output logic [63:0] ed);
    ev = 2'b00;
    ed = 64'h0;
    if (!r && e && v) begin
      case (c)
        2'b01:   begin ev = 2'b01; ed = {32'h0, d}; end
        2'b10:   begin ev = 2'b10; ed = {d, 32'h0}; end
        2'b11:   begin ev = 2'b11; ed = {d, d};     end
        default: begin ev = 2'b00; ed = 64'h0;      end
      endcase
    end
  endtask

  initial begin
    logic [1:0]  ev;
    logic [63:0] ed;
    logic        r, e, v;
    logic [1:0]  c;
    logic [31:0] d;

    drive(1'b1, 1'b1, 1'b1, 2'b11, 32'hAAAAAAAA);

    tbl.push_back(mk("rst_dup",     1, 1, 1, 2'b11, 32'hAAAAAAAA, 2'b00, 64'h0));
    tbl.push_back(mk("rel_dup",     0, 1, 1, 2'b11, 32'hAAAAAAAA, 2'b11, 64'hAAAAAAAA_AAAAAAAA));
    tbl.push_back(mk("noval_none",  0, 1, 0, 2'b00, 32'hAAAAAAAA, 2'b00, 64'h0));
    tbl.push_back(mk("val_none",    0, 1, 1, 2'b00, 32'hAAAAAAAA, 2'b00, 64'h0));
    tbl.push_back(mk("low",         0, 1, 1, 2'b01, 32'hAAAAAAAA, 2'b01, 64'h00000000_AAAAAAAA));
    tbl.push_back(mk("high",        0, 1, 1, 2'b10, 32'hAAAAAAAA, 2'b10, 64'hAAAAAAAA_00000000));
    tbl.push_back(mk("dup",         0, 1, 1, 2'b11, 32'hAAAAAAAA, 2'b11, 64'hAAAAAAAA_AAAAAAAA));
    tbl.push_back(mk("en_off",      0, 0, 1, 2'b11, 32'hAAAAAAAA, 2'b00, 64'h0));
    tbl.push_back(mk("en_on",       0, 1, 1, 2'b11, 32'hAAAAAAAA, 2'b11, 64'hAAAAAAAA_AAAAAAAA));
    tbl.push_back(mk("data_chg",    0, 1, 1, 2'b11, 32'hBBBBBBBB, 2'b11, 64'hBBBBBBBB_BBBBBBBB));
    tbl.push_back(mk("cmd_to_low",  0, 1, 1, 2'b01, 32'hBBBBBBBB, 2'b01, 64'h00000000_BBBBBBBB));
    tbl.push_back(mk("cmd_to_high", 0, 1, 1, 2'b10, 32'hBBBBBBBB, 2'b10, 64'hBBBBBBBB_00000000));
    tbl.push_back(mk("noval_low",   0, 1, 0, 2'b01, 32'h12345678, 2'b00, 64'h0));
    tbl.push_back(mk("noval_dup",   0, 1, 0, 2'b11, 32'h12345678, 2'b00, 64'h0));
    tbl.push_back(mk("rst_low",     1, 1, 1, 2'b01, 32'h12345678, 2'b00, 64'h0));
    tbl.push_back(mk("high_ones",   0, 1, 1, 2'b10, 32'hFFFFFFFF, 2'b10, 64'hFFFFFFFF_00000000));
    tbl.push_back(mk("low_pat",     0, 1, 1, 2'b01, 32'h80000001, 2'b01, 64'h00000000_80000001));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i].rst, tbl[i].en, tbl[i].valid, tbl[i].cmd, tbl[i].data);
      #2;
      check(tbl[i].name, tbl[i].ev, tbl[i].ed);
    end

    // Reset asserted and released mid-cycle, away from any clock edge
    @(negedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 2'b11, 32'hCAFEF00D);
    #1 check("pre_async_rst", 2'b11, 64'hCAFEF00D_CAFEF00D);
    rst = 1'b1;
    #1 check("async_rst_on", 2'b00, 64'h0);
    rst = 1'b0;
    #1 check("async_rst_off", 2'b11, 64'hCAFEF00D_CAFEF00D);

    // Held across clock edges: no state, outputs stay tied to inputs
    repeat (3) @(posedge clk);
    #1 check("hold_edges", 2'b11, 64'hCAFEF00D_CAFEF00D);
    i_cmd = 2'b01;
    #1 check("hold_cmd_low", 2'b01, 64'h00000000_CAFEF00D);
    i_en = 1'b0;
    #1 check("hold_en_off", 2'b00, 64'h0);
    i_en = 1'b1;
    #1 check("hold_en_back", 2'b01, 64'h00000000_CAFEF00D);

    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      r = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 5) != 0);
      v = ($urandom_range(0, 4) != 0);
      c = 2'($urandom_range(0, 3));
      d = $urandom;
      drive(r, e, v, c, d);
      #2;
      model(r, e, v, c, d, ev, ed);
      check("random", ev, ed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
